// File: rtl/alu_decode_pkg.sv
// alu_decode_pkg
//   Shared definitions for the ALU decode stage: opcode constants, the
//   output class and prefix-state enums, and the immediate width rule.
package alu_decode_pkg;

    localparam logic [3:0] OP_NULL   = 4'h0;
    localparam logic [3:0] OP_UNARY  = 4'hC;
    localparam logic [3:0] OP_JUMP   = 4'hD;
    localparam logic [3:0] OP_INCR   = 4'hE;
    localparam logic [3:0] OP_PREFIX = 4'hF;

    localparam logic [3:0] ALU_OP_ADD   = 4'h1;
    localparam logic [1:0] LOAD_SRC_REG = 2'b01;

    // Widest immediate source the width rule can handle (5R must fit).
    localparam int IMM_MAX_W = 64;

    typedef enum logic [2:0] {
        CLS_NULL   = 3'd0,
        CLS_BINARY = 3'd1,
        CLS_UNARY  = 3'd2,
        CLS_INCR   = 3'd3,
        CLS_JUMP   = 3'd4
    } out_class_e;

    typedef enum logic {
        PFX_IDLE     = 1'b0,
        PFX_PREFIXED = 1'b1
    } pfx_state_e;

    // Sign-extend the low src_w bits of src to IMM_MAX_W bits. Taking the
    // low D bits of the result gives sign extension when D > src_w and
    // plain truncation otherwise, so one function covers both cases.
    function automatic logic [IMM_MAX_W-1:0] imm_extend(
        input logic [IMM_MAX_W-1:0] src,
        input int                   src_w
    );
        logic [IMM_MAX_W-1:0] res;
        for (int i = 0; i < IMM_MAX_W; i++)
            res[i] = (i < src_w) ? src[i] : src[src_w-1];
        return res;
    endfunction

endpackage

// File: rtl/alu_decode_comb.sv
// alu_decode_comb
//   Purely combinational instruction -> ALU control field decode.
//   Ports:
//     instr        : raw instruction, opcode in the top 4 bits
//     pfx          : latched prefix payload (3R bits)
//     pfx_state    : current prefix state
//     is_prefix    : instruction is a PREFIX (produces no output word)
//     cls ..       : decoded fields, registered by the top level
//     prefix_err   : a pending prefix meets a non-INCR instruction
module alu_decode_comb
    import alu_decode_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 4,
    parameter int DATA_WIDTH     = 16,
    parameter int INSTR_WIDTH    = 4 + 3*REG_ADDR_WIDTH
) (
    input  logic [INSTR_WIDTH-1:0]      instr,
    input  logic [3*REG_ADDR_WIDTH-1:0] pfx,
    input  pfx_state_e                  pfx_state,
    output logic                        is_prefix,
    output out_class_e                  cls,
    output logic [3:0]                  alu_op,
    output logic [REG_ADDR_WIDTH-1:0]   a_sel,
    output logic [REG_ADDR_WIDTH-1:0]   b_sel,
    output logic [REG_ADDR_WIDTH-1:0]   out_sel,
    output logic                        b_source,
    output logic [DATA_WIDTH-1:0]       b_altern,
    output logic [1:0]                  load_src,
    output logic                        pc_increment,
    output logic [INSTR_WIDTH-1:0]      raw_instr,
    output logic                        prefix_err
);
    localparam int R = REG_ADDR_WIDTH;
    localparam int W = INSTR_WIDTH;

    logic [3:0]     opc;
    logic [2*R-1:0] imm;

    assign opc       = instr[W-1:W-4];
    assign imm       = instr[W-5:R];
    assign is_prefix = (opc == OP_PREFIX);
    // A pending prefix only makes sense in front of INCR.
    assign prefix_err = (pfx_state == PFX_PREFIXED) && (opc != OP_PREFIX) && (opc != OP_INCR);

    always_comb begin
        cls          = CLS_NULL;
        alu_op       = '0;
        a_sel        = '0;
        b_sel        = '0;
        out_sel      = '0;
        b_source     = 1'b0;
        b_altern     = '0;
        load_src     = '0;
        pc_increment = 1'b0;
        raw_instr    = '0;
        case (opc)
            OP_NULL: begin
                cls          = CLS_NULL;
                pc_increment = 1'b1;
                raw_instr    = instr;
            end
            OP_UNARY: begin
                cls          = CLS_UNARY;
                pc_increment = 1'b1;
                raw_instr    = instr;
            end
            OP_JUMP: begin
                cls          = CLS_JUMP;
                pc_increment = 1'b1;
                raw_instr    = instr;
            end
            OP_INCR: begin
                cls          = CLS_INCR;
                alu_op       = ALU_OP_ADD;
                a_sel        = instr[R-1:0];
                out_sel      = instr[R-1:0];
                b_source     = 1'b1;
                load_src     = LOAD_SRC_REG;
                pc_increment = 1'b1;
                if (pfx_state == PFX_PREFIXED)
                    b_altern = DATA_WIDTH'(imm_extend(IMM_MAX_W'({pfx, imm}), 5*R));
                else
                    b_altern = DATA_WIDTH'(imm_extend(IMM_MAX_W'(imm), 2*R));
            end
            OP_PREFIX: begin
                cls = CLS_NULL;
            end
            default: begin
                cls          = CLS_BINARY;
                alu_op       = opc;
                a_sel        = instr[3*R-1:2*R];
                b_sel        = instr[2*R-1:R];
                out_sel      = instr[R-1:0];
                load_src     = LOAD_SRC_REG;
                pc_increment = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_decode_stage.sv
// alu_decode_stage
//   Registered ALU decode stage with valid/ready on both sides and an
//   extended-immediate prefix state machine.
//   Ports:
//     clk, reset (async, active high), flush (sync discard)
//     in_valid / in_ready / in_instr        : instruction side
//     out_valid / out_ready                 : execute side handshake
//     out_class, alu_*, b_altern, pc_increment, raw_instr, prefix_err :
//       decoded word, held stable while out_valid && !out_ready
module alu_decode_stage
    import alu_decode_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 4,
    parameter int DATA_WIDTH     = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            flush,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [4+3*REG_ADDR_WIDTH-1:0]   in_instr,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [2:0]                      out_class,
    output logic [3:0]                      alu_op,
    output logic [REG_ADDR_WIDTH-1:0]       alu_a_select,
    output logic [REG_ADDR_WIDTH-1:0]       alu_b_select,
    output logic [REG_ADDR_WIDTH-1:0]       alu_out_select,
    output logic                            alu_b_source,
    output logic [DATA_WIDTH-1:0]           b_altern,
    output logic [1:0]                      alu_load_src,
    output logic                            alu_store_to_mem,
    output logic                            alu_store_to_stk,
    output logic                            pc_increment,
    output logic [4+3*REG_ADDR_WIDTH-1:0]   raw_instr,
    output logic                            prefix_err
);
    localparam int R = REG_ADDR_WIDTH;
    localparam int W = 4 + 3*R;

    pfx_state_e     state;
    logic [3*R-1:0] pfx;
    out_class_e     cls_q;

    logic            d_is_prefix;
    out_class_e      d_cls;
    logic [3:0]      d_alu_op;
    logic [R-1:0]    d_a_sel, d_b_sel, d_out_sel;
    logic            d_b_source;
    logic [DATA_WIDTH-1:0] d_b_altern;
    logic [1:0]      d_load_src;
    logic            d_pc_inc;
    logic [W-1:0]    d_raw;
    logic            d_prefix_err;
    logic            accept;

    alu_decode_comb #(
        .REG_ADDR_WIDTH (R),
        .DATA_WIDTH     (DATA_WIDTH),
        .INSTR_WIDTH    (W)
    ) u_comb (
        .instr        (in_instr),
        .pfx          (pfx),
        .pfx_state    (state),
        .is_prefix    (d_is_prefix),
        .cls          (d_cls),
        .alu_op       (d_alu_op),
        .a_sel        (d_a_sel),
        .b_sel        (d_b_sel),
        .out_sel      (d_out_sel),
        .b_source     (d_b_source),
        .b_altern     (d_b_altern),
        .load_src     (d_load_src),
        .pc_increment (d_pc_inc),
        .raw_instr    (d_raw),
        .prefix_err   (d_prefix_err)
    );

    // Flush blocks input so nothing is accepted into a stage being emptied.
    assign in_ready = !flush && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    assign out_class        = cls_q;
    assign alu_store_to_mem = 1'b0;
    assign alu_store_to_stk = 1'b0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid      <= 1'b0;
            state          <= PFX_IDLE;
            pfx            <= '0;
            cls_q          <= CLS_NULL;
            alu_op         <= '0;
            alu_a_select   <= '0;
            alu_b_select   <= '0;
            alu_out_select <= '0;
            alu_b_source   <= 1'b0;
            b_altern       <= '0;
            alu_load_src   <= '0;
            pc_increment   <= 1'b0;
            raw_instr      <= '0;
            prefix_err     <= 1'b0;
        end else if (flush) begin
            // Any held word counts as consumed; it is not replayed.
            out_valid <= 1'b0;
            state     <= PFX_IDLE;
            pfx       <= '0;
        end else begin
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            if (accept) begin
                if (d_is_prefix) begin
                    // A prefix emits nothing; a second one replaces the first.
                    pfx   <= in_instr[3*R-1:0];
                    state <= PFX_PREFIXED;
                end else begin
                    out_valid      <= 1'b1;
                    state          <= PFX_IDLE;
                    pfx            <= '0;
                    cls_q          <= d_cls;
                    alu_op         <= d_alu_op;
                    alu_a_select   <= d_a_sel;
                    alu_b_select   <= d_b_sel;
                    alu_out_select <= d_out_sel;
                    alu_b_source   <= d_b_source;
                    b_altern       <= d_b_altern;
                    alu_load_src   <= d_load_src;
                    pc_increment   <= d_pc_inc;
                    raw_instr      <= d_raw;
                    prefix_err     <= d_prefix_err;
                end
            end
        end
    end

endmodule
